// File: rtl/stego_pkg.sv
// Shared constants and state type for the base-27 pixel-triple stego path.
// Used by both the extractor and the mod-27 reduction block.
package stego_pkg;

    localparam int MOD_BASE   = 27;
    localparam int W0         = 1;
    localparam int W1         = 3;
    localparam int W2         = 9;
    localparam int NIBBLE_MAX = 15;
    localparam int SUM_W      = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FF,
        ST_RD_FF,
        ST_CALC,
        ST_WR_FF,
        ST_DONE
    } ext_state_t;

endpackage

// File: rtl/stego_mod27.sv
// Combinational f = (p0 + 3*p1 + 9*p2) mod 27 using conditional-subtract stages.
// There is no divider, so this block can be shared with the embed path.
module stego_mod27
    import stego_pkg::*;
(
    input  logic [7:0] p0,
    input  logic [7:0] p1,
    input  logic [7:0] p2,
    output logic [4:0] f
);

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] rem;

    // The maximum sum is 3315, which is below 27*128, so stages 27*64 down to 27*1 are sufficient.
    always_comb begin
        sum = SUM_W'(p0) * SUM_W'(W0) + SUM_W'(p1) * SUM_W'(W1) + SUM_W'(p2) * SUM_W'(W2);
        rem = sum;
        for (int k = 6; k >= 0; k--) begin
            if (rem >= SUM_W'(MOD_BASE << k)) begin
                rem = rem - SUM_W'(MOD_BASE << k);
            end
        end
        f = rem[4:0];
    end

endmodule

// File: rtl/stego_extractor.sv
// Streaming base-27 stego decoder: 3 pixels -> 1 nibble, 2 nibbles -> 1 message byte.
// Optional STEGO_EXT_CHECKSUM_EN appends an XOR checksum byte after the message.
module stego_extractor
    import stego_pkg::*;
#(
    parameter int FF_DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [15:0]              msg_bytes,
    input  logic [FF_DATA_WIDTH-1:0] ff_pixel_data,
    input  logic                     ff_pixel_empty,
    output logic                     ff_pixel_rd,
    input  logic                     ff_full,
    output logic [FF_DATA_WIDTH-1:0] ff_data,
    output logic                     ff_wr,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               err_cnt
);

    ext_state_t               state;
    logic [15:0]              byte_left;
    logic [1:0]               pix_cnt;
    logic                     nib_sel;
    logic [FF_DATA_WIDTH-1:0] pix0, pix1, pix2;
    logic [FF_DATA_WIDTH-1:0] msg_byte;
    logic [4:0]               f;
`ifdef STEGO_EXT_CHECKSUM_EN
    logic [FF_DATA_WIDTH-1:0] chk;
    logic                     chk_phase;
`endif

    stego_mod27 u_mod27 (
        .p0 (pix0),
        .p1 (pix1),
        .p2 (pix2),
        .f  (f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            byte_left   <= '0;
            pix_cnt     <= '0;
            nib_sel     <= 1'b0;
            pix0        <= '0;
            pix1        <= '0;
            pix2        <= '0;
            msg_byte    <= '0;
            ff_pixel_rd <= 1'b0;
            ff_wr       <= 1'b0;
            ff_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_cnt     <= '0;
`ifdef STEGO_EXT_CHECKSUM_EN
            chk         <= '0;
            chk_phase   <= 1'b0;
`endif
        end else begin
            ff_pixel_rd <= 1'b0;
            ff_wr       <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        byte_left <= msg_bytes;
                        err_cnt   <= '0;
                        pix_cnt   <= '0;
                        nib_sel   <= 1'b0;
`ifdef STEGO_EXT_CHECKSUM_EN
                        chk       <= '0;
                        chk_phase <= (msg_bytes == 16'd0);
                        msg_byte  <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= (msg_bytes == 16'd0) ? ST_WR_FF : ST_WAIT_FF;
`else
                        busy      <= (msg_bytes != 16'd0);
                        done      <= (msg_bytes == 16'd0);
                        state     <= (msg_bytes == 16'd0) ? ST_DONE : ST_WAIT_FF;
`endif
                    end
                end
                ST_WAIT_FF: begin
                    if (!ff_pixel_empty) begin
                        ff_pixel_rd <= 1'b1;
                        state       <= ST_RD_FF;
                    end
                end
                ST_RD_FF: begin
                    case (pix_cnt)
                        2'd0:    pix0 <= ff_pixel_data;
                        2'd1:    pix1 <= ff_pixel_data;
                        default: pix2 <= ff_pixel_data;
                    endcase
                    if (pix_cnt == 2'd2) begin
                        pix_cnt <= '0;
                        state   <= ST_CALC;
                    end else begin
                        pix_cnt <= pix_cnt + 2'd1;
                        state   <= ST_WAIT_FF;
                    end
                end
                ST_CALC: begin
                    if (f > 5'(NIBBLE_MAX) && err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                    if (!nib_sel) begin
                        msg_byte[7:4] <= f[3:0];
                        nib_sel       <= 1'b1;
                        state         <= ST_WAIT_FF;
                    end else begin
                        msg_byte[3:0] <= f[3:0];
                        nib_sel       <= 1'b0;
                        state         <= ST_WR_FF;
                    end
                end
                ST_WR_FF: begin
                    // The !ff_wr term leaves a gap before a checksum byte that follows a message byte.
                    if (!ff_full && !ff_wr) begin
                        ff_wr   <= 1'b1;
                        ff_data <= msg_byte;
`ifdef STEGO_EXT_CHECKSUM_EN
                        if (chk_phase) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            chk       <= chk ^ msg_byte;
                            byte_left <= byte_left - 16'd1;
                            if (byte_left == 16'd1) begin
                                msg_byte  <= chk ^ msg_byte;
                                chk_phase <= 1'b1;
                            end else begin
                                state <= ST_WAIT_FF;
                            end
                        end
`else
                        byte_left <= byte_left - 16'd1;
                        if (byte_left == 16'd1) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_WAIT_FF;
                        end
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stego_extractor.sv
// Self-checking bench for stego_extractor: directed vector table, corner sequences
// and randomized runs against an arithmetic mod-27 reference model.
module tb_stego_extractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] msg_bytes = '0;
    logic [7:0]  ff_pixel_data = '0;
    logic        ff_pixel_empty = 1'b1;
    logic        ff_pixel_rd;
    logic        ff_full = 1'b0;
    logic [7:0]  ff_data;
    logic        ff_wr;
    logic        busy;
    logic        done;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    stego_extractor #(.FF_DATA_WIDTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .msg_bytes      (msg_bytes),
        .ff_pixel_data  (ff_pixel_data),
        .ff_pixel_empty (ff_pixel_empty),
        .ff_pixel_rd    (ff_pixel_rd),
        .ff_full        (ff_full),
        .ff_data        (ff_data),
        .ff_wr          (ff_wr),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt)
    );

    int total = 0;
    int bad = 0;

    logic [7:0] pix_q[$];
    logic [7:0] out_q[$];
    int  pops = 0;
    int  cyc = 0;
    int  pop_edge = 0;
    int  first_lat = -1;
    int  hold = 0;
    int  viol = 0;
    bit  starve = 1'b0;
    bit  prev_rd = 1'b0;
    bit  prev_wr = 1'b0;

    always @(posedge clk) cyc++;

    // Show-ahead-free pixel FIFO and output FIFO models, plus protocol monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ff_pixel_rd) begin
                    if (ff_pixel_empty || pix_q.size() == 0) viol++;
                    else ff_pixel_data = pix_q.pop_front();
                    pops++;
                    pop_edge = cyc + 1;
                    if (starve) hold = 3;
                end else if (hold > 0) begin
                    hold--;
                end
                if (ff_wr) begin
                    out_q.push_back(ff_data);
                    if (first_lat < 0) first_lat = cyc - pop_edge;
                    if (ff_full) viol++;
                end
                if ((ff_pixel_rd && prev_rd) || (ff_wr && prev_wr)) viol++;
            end
            prev_rd = ff_pixel_rd;
            prev_wr = ff_wr;
            ff_pixel_empty = (pix_q.size() == 0) || (hold > 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int nib(input int a, input int b, input int c);
        return (a + 3 * b + 9 * c) % 27;
    endfunction

    task automatic push3(input int a, input int b, input int c);
        pix_q.push_back(8'(a));
        pix_q.push_back(8'(b));
        pix_q.push_back(8'(c));
    endtask

    task automatic start_run(input int n);
        out_q.delete();
        first_lat = -1;
        msg_bytes = 16'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rand_full);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            if (rand_full) ff_full = ($urandom_range(0, 3) == 0);
            tick();
        end
        ff_full = 1'b0;
        check("done_reached", int'(done), 1);
    endtask

    // Checks the output byte stream against an expected message, adding the checksum when enabled.
    task automatic check_stream(input string name, input logic [7:0] exp_q[$]);
        logic [7:0] x;
        x = '0;
        foreach (exp_q[i]) x = x ^ exp_q[i];
`ifdef STEGO_EXT_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        check({name, "_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check({name, "_byte"}, (i < out_q.size()) ? int'(out_q[i]) : -1, int'(exp_q[i]));
        end
    endtask

    typedef struct {
        int         p[6];
        logic [7:0] exp_byte;
        int         exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] exp_q[$];
        int base;
        int n, e, fa, fb;
        int px[6];

        vecs[0].p = '{1, 2, 0, 3, 0, 0};         vecs[0].exp_byte = 8'h73; vecs[0].exp_err = 0;
        vecs[1].p = '{255, 255, 255, 0, 0, 1};   vecs[1].exp_byte = 8'h59; vecs[1].exp_err = 1;
        vecs[2].p = '{0, 0, 1, 2, 1, 0};         vecs[2].exp_byte = 8'h95; vecs[2].exp_err = 0;
        vecs[3].p = '{15, 0, 0, 0, 5, 0};        vecs[3].exp_byte = 8'hFF; vecs[3].exp_err = 0;
        vecs[4].p = '{16, 0, 0, 26, 0, 0};       vecs[4].exp_byte = 8'h0A; vecs[4].exp_err = 2;
        vecs[5].p = '{255, 0, 0, 0, 255, 0};     vecs[5].exp_byte = 8'hC9; vecs[5].exp_err = 0;
        vecs[6].p = '{0, 0, 0, 0, 0, 0};         vecs[6].exp_byte = 8'h00; vecs[6].exp_err = 0;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_outputs", int'({ff_pixel_rd, ff_wr, ff_data, busy, done, err_cnt}), 0);
        rst_n = 1'b1;
        tick();

        // Back-pressure: output full for 10 cycles once the first byte is ready
        push3(0, 0, 1); push3(2, 1, 0); push3(0, 0, 1); push3(2, 1, 0);
        ff_full = 1'b1;
        base = pops;
        start_run(2);
        check("busy_after_start", int'(busy), 1);
        for (int i = 0; i < 100 && pops - base < 6; i++) tick();
        check("bp_pixels_popped", pops - base, 6);
        for (int i = 0; i < 10; i++) tick();
        check("bp_no_write", out_q.size(), 0);
        check("bp_data_held", int'(ff_data), 0);
        ff_full = 1'b0;
        wait_done(200, 1'b0);
        exp_q = '{8'h95, 8'h95};
        check_stream("bp", exp_q);
        check("bp_err", int'(err_cnt), 0);

        // Directed vector table, single-byte messages
        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < 6; k += 3) push3(vecs[v].p[k], vecs[v].p[k+1], vecs[v].p[k+2]);
            start_run(1);
            check("vec_busy", int'(busy), 1);
            check("vec_done_cleared", int'(done), 0);
            wait_done(200, 1'b0);
            exp_q = '{vecs[v].exp_byte};
            check_stream("vec", exp_q);
            check("vec_err", int'(err_cnt), vecs[v].exp_err);
            check("vec_busy_low", int'(busy), 0);
            check("vec_latency", first_lat, 2);
        end

        // Two-byte message (checksum 0x73^0x95 = 0xE6 when enabled)
        push3(1, 2, 0); push3(3, 0, 0); push3(0, 0, 1); push3(2, 1, 0);
        start_run(2);
        wait_done(200, 1'b0);
        exp_q = '{8'h73, 8'h95};
        check_stream("two_byte", exp_q);

        // Starved pixel FIFO
        starve = 1'b1;
        push3(1, 2, 0); push3(3, 0, 0); push3(255, 255, 255); push3(0, 0, 1);
        start_run(2);
        wait_done(400, 1'b0);
        starve = 1'b0;
        exp_q = '{8'h73, 8'h59};
        check_stream("starve", exp_q);
        check("starve_err", int'(err_cnt), 1);

        // Zero length
        base = pops;
        start_run(0);
        wait_done(20, 1'b0);
        tick();
        check("zero_no_pop", pops - base, 0);
        exp_q.delete();
        check_stream("zero", exp_q);
        check("zero_busy", int'(busy), 0);

        // Reset mid-run after 4 pixels
        push3(255, 0, 0); push3(0, 255, 0);
        base = pops;
        start_run(1);
        for (int i = 0; i < 100 && pops - base < 4; i++) tick();
        check("mid_pixels_popped", pops - base, 4);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", int'({ff_pixel_rd, ff_wr, ff_data, busy, done, err_cnt}), 0);
        tick();
        pix_q.delete();
        hold = 0;
        rst_n = 1'b1;
        tick();
        push3(0, 0, 0); push3(15, 0, 0);
        start_run(1);
        wait_done(200, 1'b0);
        exp_q = '{8'h0F};
        check_stream("after_reset", exp_q);

        // Error counter saturation: 130 bytes, 260 invalid nibbles
        for (int i = 0; i < 260; i++) push3(255, 255, 255);
        start_run(130);
        wait_done(6000, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 130; i++) exp_q.push_back(8'h55);
        check_stream("sat", exp_q);
        check("sat_err", int'(err_cnt), 255);

        // Randomized runs against the arithmetic model
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(1, 6);
            starve = ($urandom_range(0, 1) == 1);
            exp_q.delete();
            e = 0;
            for (int b = 0; b < n; b++) begin
                for (int k = 0; k < 6; k++) px[k] = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
                for (int k = 0; k < 6; k += 3) push3(px[k], px[k+1], px[k+2]);
                fa = nib(px[0], px[1], px[2]);
                fb = nib(px[3], px[4], px[5]);
                if (fa > 15) e++;
                if (fb > 15) e++;
                exp_q.push_back(8'((fa % 16) * 16 + (fb % 16)));
            end
            start_run(n);
            wait_done(2000, 1'b1);
            starve = 1'b0;
            check_stream("rand", exp_q);
            check("rand_err", int'(err_cnt), (e > 255) ? 255 : e);
        end

        tick();
        check("protocol_violations", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
